// File: rtl/eth_rx_fcs_checker.sv
// Ethernet receive FCS checker: CRC-32 residue check, length status, stream forwarding.
// Define ETH_RX_FCS_STRIP_EN to strip the 4-byte FCS from the forwarded stream.
module eth_rx_fcs_checker #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_abort,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        stat_valid,
  output logic        stat_fcs_ok,
  output logic        stat_len_err,
  output logic        stat_abort,
  output logic [10:0] stat_len
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] LEN_SAT = 11'd2047;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    STAT
  } state_t;

  state_t      state_q;
  logic [31:0] crc_q;
  logic [10:0] cnt_q;

  logic        acc;
  logic        start;
  logic        abort_ev;
  logic [31:0] crc_base;
  logic [31:0] crc_nxt;
  logic [10:0] cnt_base;
  logic [10:0] cnt_inc;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic len_bad(input logic [10:0] l);
    return ({21'd0, l} < MIN_LEN[31:0]) ||
           ({21'd0, l} > MAX_LEN[31:0]);
  endfunction

  // Byte acceptance, frame start detection, next CRC and saturating count
  always_comb begin
    acc      = in_valid & ~in_abort;
    start    = acc & (state_q != RX);
    abort_ev = (state_q == RX) & in_abort;
    crc_base = start ? 32'hFFFF_FFFF : crc_q;
    crc_nxt  = crc_upd(crc_base, in_data);
    cnt_base = start ? 11'd0 : cnt_q;
    cnt_inc  = (cnt_base == LEN_SAT) ? cnt_base : cnt_base + 11'd1;
  end

  // Frame FSM with CRC/length accumulation and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      crc_q        <= 32'hFFFF_FFFF;
      cnt_q        <= 11'd0;
      stat_valid   <= 1'b0;
      stat_fcs_ok  <= 1'b0;
      stat_len_err <= 1'b0;
      stat_abort   <= 1'b0;
      stat_len     <= 11'd0;
    end else begin
      stat_valid <= 1'b0;
      unique case (state_q)
        IDLE, STAT: begin
          if (acc && in_last) begin
            state_q      <= STAT;
            stat_valid   <= 1'b1;
            stat_fcs_ok  <= 1'b0;
            stat_len_err <= 1'b1;
            stat_abort   <= 1'b0;
            stat_len     <= 11'd1;
            crc_q        <= 32'hFFFF_FFFF;
            cnt_q        <= 11'd0;
          end else if (acc) begin
            state_q <= RX;
            crc_q   <= crc_nxt;
            cnt_q   <= cnt_inc;
          end else begin
            state_q <= IDLE;
          end
        end
        RX: begin
          if (in_abort) begin
            state_q      <= STAT;
            stat_valid   <= 1'b1;
            stat_fcs_ok  <= 1'b0;
            stat_len_err <= len_bad(cnt_q);
            stat_abort   <= 1'b1;
            stat_len     <= cnt_q;
            crc_q        <= 32'hFFFF_FFFF;
            cnt_q        <= 11'd0;
          end else if (in_valid) begin
            crc_q <= crc_nxt;
            cnt_q <= cnt_inc;
            if (in_last) begin
              state_q      <= STAT;
              stat_valid   <= 1'b1;
              stat_fcs_ok  <= (crc_nxt == RESIDUE);
              stat_len_err <= len_bad(cnt_inc);
              stat_abort   <= 1'b0;
              stat_len     <= cnt_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ETH_RX_FCS_STRIP_EN
  logic [3:0][7:0] dly_q;
  logic [2:0]      fill_q;
  logic [2:0]      fill_base;
  logic            full;

  // Delay-line occupancy as seen by the byte on the input this cycle
  always_comb begin
    fill_base = start ? 3'd0 : fill_q;
    full      = (fill_base == 3'd4);
  end

  // Four-byte delay line; bytes still inside it at frame end are the FCS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q     <= '0;
      fill_q    <= 3'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (abort_ev) begin
        fill_q   <= 3'd0;
        out_last <= 1'b1;
      end else if (acc) begin
        dly_q  <= {dly_q[2:0], in_data};
        fill_q <= in_last ? 3'd0 : (full ? 3'd4 : fill_base + 3'd1);
        if (full) begin
          out_valid <= 1'b1;
          out_data  <= dly_q[3];
          out_last  <= in_last;
        end
      end
    end
  end
`else
  // Forward every accepted byte one cycle later, FCS included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= acc;
      out_last  <= (acc & in_last) | abort_ev;
      if (acc) begin
        out_data <= in_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_checker.sv
// Testbench for eth_rx_fcs_checker: table of frames plus hand-written corner sequences.
// Two instances share stimulus: default lengths and MIN_LEN=4.
module tb_eth_rx_fcs_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_abort;

  logic [7:0]  d_out_data, m_out_data;
  logic        d_out_valid, m_out_valid;
  logic        d_out_last, m_out_last;
  logic        d_sv, m_sv;
  logic        d_ok, m_ok;
  logic        d_err, m_err;
  logic        d_ab, m_ab;
  logic [10:0] d_len, m_len;

  eth_rx_fcs_checker u_def (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_abort(in_abort),
    .out_data(d_out_data), .out_valid(d_out_valid),
    .out_last(d_out_last), .stat_valid(d_sv),
    .stat_fcs_ok(d_ok), .stat_len_err(d_err),
    .stat_abort(d_ab), .stat_len(d_len)
  );

  eth_rx_fcs_checker #(.MIN_LEN(4), .MAX_LEN(1518)) u_m4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_abort(in_abort),
    .out_data(m_out_data), .out_valid(m_out_valid),
    .out_last(m_out_last), .stat_valid(m_sv),
    .stat_fcs_ok(m_ok), .stat_len_err(m_err),
    .stat_abort(m_ab), .stat_len(m_len)
  );

`ifdef ETH_RX_FCS_STRIP_EN
  localparam int EXP_OUT = 9;
`else
  localparam int EXP_OUT = 13;
`endif

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        ab;
    logic [10:0] len;
  } st_t;

  typedef struct {
    int kind;
    int n;
    bit flip;
    int abort_at;
    bit gaps;
    bit use4;
    bit e_ok;
    int e_len;
    bit e_err;
    bit e_ab;
  } vec_t;

  st_t        q_def[$];
  st_t        q_m4[$];
  logic [8:0] oq[$];
  logic [7:0] fr[$];
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (d_sv) q_def.push_back({d_ok, d_err, d_ab, d_len});
      if (m_sv) q_m4.push_back({m_ok, m_err, m_ab, m_len});
      if (d_out_valid) oq.push_back({d_out_last, d_out_data});
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic build(input int kind, input int n, input bit flip);
    logic [31:0] c;
    logic [7:0]  b;
    fr.delete();
    if (kind == 0) begin
      for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
      fr.push_back(8'h26);
      fr.push_back(8'h39);
      fr.push_back(8'hF4);
      fr.push_back(flip ? 8'hCA : 8'hCB);
    end else if (kind == 1) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) begin
        b = 8'((i * 7 + 3) & 255);
        fr.push_back(b);
        c = crc_upd(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    end else begin
      for (int i = 0; i < n; i++) fr.push_back(8'(i));
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_abort = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic send(input bit gaps, input int abort_at, input int stop_at);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      in_data  = fr[i];
      in_valid = 1'b1;
      in_last  = (i == fr.size() - 1);
      in_abort = (abort_at == i + 1);
      @(posedge clk); #1;
      if (abort_at == i + 1 || stop_at == i + 1) break;
    end
  endtask

  task automatic clear();
    q_def.delete();
    q_m4.delete();
    oq.delete();
  endtask

  task automatic check_stat(input string tag, input bit use4, input bit e_ok,
                            input int e_len, input bit e_err, input bit e_ab);
    int  k;
    st_t s;
    k = 0;
    while ((use4 ? q_m4.size() : q_def.size()) == 0 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, ".npulse"}, use4 ? q_m4.size() : q_def.size(), 1);
    if ((use4 ? q_m4.size() : q_def.size()) > 0) begin
      s = use4 ? q_m4[0] : q_def[0];
      chk({tag, ".fcs_ok"}, s.ok, e_ok);
      chk({tag, ".len"}, s.len, e_len);
      chk({tag, ".len_err"}, s.err, e_err);
      chk({tag, ".abort"}, s.ab, e_ab);
    end
  endtask

  vec_t tv[12];
  int   k;

  initial begin
    tv[0]  = '{0, 13, 0, 0, 0, 1, 1, 13, 0, 0};
    tv[1]  = '{0, 13, 1, 0, 0, 1, 0, 13, 0, 0};
    tv[2]  = '{1, 60, 0, 0, 0, 0, 1, 60, 1, 0};
    tv[3]  = '{1, 64, 0, 0, 1, 0, 1, 64, 0, 0};
    tv[4]  = '{1, 1518, 0, 0, 0, 0, 1, 1518, 0, 0};
    tv[5]  = '{1, 1519, 0, 0, 0, 0, 1, 1519, 1, 0};
    tv[6]  = '{1, 2100, 0, 0, 0, 0, 1, 2047, 1, 0};
    tv[7]  = '{1, 20, 0, 20, 0, 1, 0, 19, 0, 1};
    tv[8]  = '{2, 1, 0, 0, 0, 1, 0, 1, 1, 0};
    tv[9]  = '{1, 4, 0, 0, 0, 1, 1, 4, 0, 0};
    tv[10] = '{2, 3, 0, 0, 0, 1, 0, 3, 1, 0};
    tv[11] = '{1, 64, 0, 10, 1, 0, 0, 9, 1, 1};

    rst_n = 1'b0;
    idle();
    #3;
    chk("reset.def", {d_out_valid, d_out_last, d_out_data, d_sv,
                      d_ok, d_err, d_ab, d_len}, 0);
    chk("reset.m4", {m_out_valid, m_out_last, m_out_data, m_sv,
                     m_ok, m_err, m_ab, m_len}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      clear();
      build(tv[i].kind, tv[i].n, tv[i].flip);
      send(tv[i].gaps, tv[i].abort_at, 0);
      idle();
      check_stat($sformatf("vec%0d", i), tv[i].use4, tv[i].e_ok,
                 tv[i].e_len, tv[i].e_err, tv[i].e_ab);
    end

    // Abort while idle: no pulse, nothing forwarded
    clear();
    in_abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    @(posedge clk); #1;
    idle();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_abort.npulse", q_def.size(), 0);
    chk("idle_abort.nout", oq.size(), 0);

    // Bad frame, then a good frame whose first byte lands in the STAT cycle
    clear();
    build(0, 13, 1);
    send(0, 0, 0);
    build(0, 13, 0);
    send(0, 0, 0);
    idle();
    k = 0;
    while (q_m4.size() < 2 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk("b2b.npulse", q_m4.size(), 2);
    if (q_m4.size() >= 2) begin
      chk("b2b.first_ok", q_m4[0].ok, 0);
      chk("b2b.first_len", q_m4[0].len, 13);
      chk("b2b.second_ok", q_m4[1].ok, 1);
      chk("b2b.second_len", q_m4[1].len, 13);
    end

    // Forwarded stream with random gaps
    clear();
    build(0, 13, 0);
    send(1, 0, 0);
    idle();
    check_stat("stream", 1, 1, 13, 0, 0);
    chk("stream.nout", oq.size(), EXP_OUT);
    if (oq.size() == EXP_OUT) begin
      for (int i = 0; i < EXP_OUT; i++) begin
        chk($sformatf("stream.byte%0d", i), oq[i][7:0], fr[i]);
        chk($sformatf("stream.last%0d", i), oq[i][8], (i == EXP_OUT - 1));
      end
    end

    // Reset after byte 7 of a frame
    clear();
    build(1, 64, 0);
    send(0, 0, 7);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rstmid.def", {d_out_valid, d_out_last, d_out_data, d_sv,
                       d_ok, d_err, d_ab, d_len}, 0);
    chk("rstmid.m4", {m_out_valid, m_out_last, m_out_data, m_sv,
                      m_ok, m_err, m_ab, m_len}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid.npulse", q_def.size() + q_m4.size(), 0);
    clear();
    build(0, 13, 0);
    send(0, 0, 0);
    idle();
    check_stat("rstnext", 1, 1, 13, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
